decrypt_round_ctrl: RTL and testbench

- Sequences the iterative AES-128 inverse-cipher round datapath (`decrypt`: InvShiftRows → InvSubBytes → AddKey → InvMixColumns) over 10 rounds for one 128-bit block at a time.
- Accepts ciphertext on a valid/ready port and performs the initial AddRoundKey with key 10 itself.
- Drives datapath data, round key and last_round; reads round keys from the key-schedule store by index; returns plaintext on a valid/ready port.

---
 rtl/aes_dec_pkg.sv | 15 +
 rtl/decrypt_round_ctrl.sv | 96 +++++++++
 tb/tb_decrypt_round_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_pkg.sv
// Shared constants and FSM state type for the AES-128 inverse-cipher round controller.
package aes_dec_pkg;

   localparam int NUM_ROUNDS = 10;
   localparam int KEY_IDX_W  = 4;
   localparam int BLOCK_W    = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } dec_state_e;

endpackage

// File: rtl/decrypt_round_ctrl.sv
// Sequences one AES-128 block through ten inverse-cipher rounds on an external
// registered round datapath, doing the initial AddRoundKey (key 10) locally.
module decrypt_round_ctrl
   import aes_dec_pkg::*;
#(
   parameter int DP_LAT = 1
) (
   input  logic           clk,
   input  logic           n_rst,
   input  logic           key_ready,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [127:0]   in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [127:0]   out_data,
   output logic [3:0]     key_addr,
   input  logic [127:0]   key_data,
   output logic [127:0]   dp_data,
   output logic [127:0]   dp_round_key,
   output logic           dp_last_round,
   input  logic [127:0]   dp_decrypted,
   output logic           busy
);

   localparam logic [2:0]           LAT      = 3'(DP_LAT);
   localparam logic [KEY_IDX_W-1:0] LAST_KEY = KEY_IDX_W'(NUM_ROUNDS);

   dec_state_e             fsm;
   logic [BLOCK_W-1:0]     state_q;
   logic [KEY_IDX_W-1:0]   rnd;
   logic [2:0]             wait_cnt;

   assign out_data     = state_q;
   assign dp_data      = state_q;
   assign dp_round_key = key_data;

   always_comb begin
      in_ready      = (fsm == IDLE) && key_ready;
      out_valid     = (fsm == DONE);
      busy          = (fsm != IDLE);
      dp_last_round = (fsm == RUN) && (rnd == '0);
      key_addr      = '0;
      if (fsm == INIT) begin
         key_addr = LAST_KEY;
      end else if (fsm == RUN) begin
         key_addr = rnd;
      end
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         fsm      <= IDLE;
         state_q  <= '0;
         rnd      <= '0;
         wait_cnt <= '0;
      end else begin
         unique case (fsm)
            IDLE: begin
               if (in_valid && in_ready) begin
                  state_q <= in_data;
                  fsm     <= INIT;
               end
            end
            INIT: begin
               state_q  <= state_q ^ key_data;
               rnd      <= LAST_KEY - 4'd1;
               wait_cnt <= '0;
               fsm      <= RUN;
            end
            RUN: begin
               // datapath inputs stay put until the registered result has settled
               if (wait_cnt == LAT) begin
                  state_q  <= dp_decrypted;
                  wait_cnt <= '0;
                  if (rnd == '0) begin
                     fsm <= DONE;
                  end else begin
                     rnd <= rnd - 4'd1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  rnd <= '0;
                  fsm <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_decrypt_round_ctrl.sv
// Bench for decrypt_round_ctrl: behavioural key store and round datapath, a
// full AES-128 decrypt reference, and a scoreboard monitor on a cycle-level model.
module tb_decrypt_round_ctrl;

   localparam int DP_LAT  = 1;
   localparam int NR      = 10;
   localparam int LAT_OUT = 2 + NR * (DP_LAT + 1);

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

   logic         clk = 1'b0;
   logic         n_rst, key_ready, in_valid, in_ready, out_valid, out_ready;
   logic         dp_last_round, busy;
   logic [127:0] in_data, out_data, key_data, dp_data, dp_round_key, dp_decrypted;
   logic [3:0]   key_addr;

   logic [7:0]   sbox [256];
   logic [7:0]   inv_sbox [256];
   logic [127:0] rk [11];
   logic [127:0] dp_pipe [DP_LAT];
   logic [127:0] exp_q [$];

   int cyc = 0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   decrypt_round_ctrl #(.DP_LAT(DP_LAT)) dut (
      .clk(clk), .n_rst(n_rst), .key_ready(key_ready),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .key_addr(key_addr), .key_data(key_data),
      .dp_data(dp_data), .dp_round_key(dp_round_key),
      .dp_last_round(dp_last_round), .dp_decrypted(dp_decrypted), .busy(busy)
   );

   // ---------------- AES arithmetic ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] gb(input logic [127:0] s, input int i);
      return s[127-8*i -: 8];
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] t);
      return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
   endfunction

   function automatic logic [127:0] rkey(input logic [127:0] key, input int idx);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
   endfunction

   function automatic logic [127:0] inv_round(input logic [127:0] d, input logic [127:0] k,
                                              input logic last);
      logic [127:0] t, u;
      logic [7:0]   a0, a1, a2, a3;
      t = '0;
      u = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            t[127-8*(r+4*c) -: 8] = inv_sbox[gb(d, r + 4*((c - r + 4) % 4))];
      t = t ^ k;
      if (last) return t;
      for (int c = 0; c < 4; c++) begin
         a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
         u[127-8*(4*c)   -: 8] = gm(a0,8'd14) ^ gm(a1,8'd11) ^ gm(a2,8'd13) ^ gm(a3,8'd9);
         u[127-8*(4*c+1) -: 8] = gm(a0,8'd9)  ^ gm(a1,8'd14) ^ gm(a2,8'd11) ^ gm(a3,8'd13);
         u[127-8*(4*c+2) -: 8] = gm(a0,8'd13) ^ gm(a1,8'd9)  ^ gm(a2,8'd14) ^ gm(a3,8'd11);
         u[127-8*(4*c+3) -: 8] = gm(a0,8'd11) ^ gm(a1,8'd13) ^ gm(a2,8'd9)  ^ gm(a3,8'd14);
      end
      return u;
   endfunction

   // Whole-block inverse cipher used as the reference for random vectors.
   function automatic logic [127:0] aes_decrypt(input logic [127:0] ct, input logic [127:0] key);
      logic [127:0] s;
      s = ct ^ rkey(key, 10);
      for (int r = 9; r >= 1; r--) s = inv_round(s, rkey(key, r), 1'b0);
      return inv_round(s, rkey(key, 0), 1'b1);
   endfunction

   // ---------------- key store and datapath models ----------------
   assign key_data     = (key_addr <= 4'd10) ? rk[key_addr] : '0;
   assign dp_decrypted = dp_pipe[DP_LAT-1];

   always @(posedge clk) begin
      dp_pipe[0] <= inv_round(dp_data, dp_round_key, dp_last_round);
      for (int i = 1; i < DP_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
   end

   task automatic set_key(input logic [127:0] k);
      for (int i = 0; i <= 10; i++) rk[i] = rkey(k, i);
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_key(input int k);
      if (k == 1) return 10;
      if (k >= 2 && k < LAT_OUT) return 9 - (k - 2) / (DP_LAT + 1);
      return 0;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   initial begin
      bit           inflight, rst_prev, prev_ov, prev_or;
      int           acc, k, ek;
      logic [127:0] prev_data, e;
      inflight = 0; rst_prev = 0; prev_ov = 0; prev_or = 0; acc = 0; prev_data = '0;
      forever begin
         @(negedge clk);
         k = cyc - acc;
         if (rst_prev) begin
            chk("rst_out_valid", 128'(out_valid), 128'(0));
            chk("rst_busy", 128'(busy), 128'(0));
            chk("rst_key_addr", 128'(key_addr), 128'(0));
            chk("rst_out_data", out_data, 128'(0));
            chk("rst_last_round", 128'(dp_last_round), 128'(0));
            chk("rst_in_ready", 128'(in_ready), 128'(key_ready));
         end else begin
            ek = inflight ? exp_key(k) : 0;
            chk("busy", 128'(busy), 128'(inflight));
            chk("in_ready", 128'(in_ready), 128'(key_ready && !inflight));
            chk("key_addr", 128'(key_addr), 128'(ek));
            chk("out_valid", 128'(out_valid), 128'(inflight && k >= LAT_OUT));
            chk("last_round", 128'(dp_last_round),
                128'(inflight && k >= 2 && k < LAT_OUT && ek == 0));
            chk("dp_data", dp_data, out_data);
            chk("dp_round_key", dp_round_key, rk[ek]);
            if (prev_ov && !prev_or) chk("hold_data", out_data, prev_data);
            if (inflight && out_valid && !prev_ov) chk("latency", 128'(k), 128'(LAT_OUT));
         end
         if (n_rst) begin
            inflight = 0;
            exp_q.delete();
         end else if (!inflight && in_valid && key_ready) begin
            inflight = 1;
            acc = cyc;
         end else if (inflight && k >= LAT_OUT && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", out_data, 128'(0));
            end else begin
               e = exp_q.pop_front();
               chk("plaintext", out_data, e);
            end
            inflight = 0;
         end
         prev_ov = out_valid; prev_or = out_ready; prev_data = out_data; rst_prev = n_rst;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [127:0] ct, input logic [127:0] pt, input bit hold);
      bit got;
      exp_q.push_back(pt);
      in_data  = ct;
      in_valid = 1'b1;
      got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (in_ready) got = 1;
      end
      if (!got) chk("accept_timeout", 128'(0), 128'(1));
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_ov();
      bit got;
      got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (out_valid) got = 1;
      end
      if (!got) chk("out_valid_timeout", 128'(0), 128'(1));
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      bit got;
      got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (!busy && !out_valid) got = 1;
      end
      if (!got) chk("idle_timeout", 128'(0), 128'(1));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0]   inv, b, s;
      logic [127:0] key, ct;
      bit           ok;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0)
            for (int y = 1; y < 256; y++)
               if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         s = inv ^ 8'h63;
         for (int n = 0; n < 4; n++) begin
            b = {b[6:0], b[7]};
            s = s ^ b;
         end
         sbox[x] = s;
      end
      for (int x = 0; x < 256; x++) inv_sbox[sbox[x]] = 8'(x);
      set_key(C1_KEY);

      n_rst = 1'b1; key_ready = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 n_rst = 1'b0;

      // FIPS-197 C.1 single block
      send(C1_CT, C1_PT, 1'b0);
      wait_idle();

      // backpressure with ignored input pulses
      out_ready = 1'b0;
      send(C1_CT, C1_PT, 1'b0);
      wait_ov();
      for (int i = 0; i < 15; i++) begin
         in_valid = i[0];
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_idle();

      // back-to-back with in_valid held high
      send(C1_CT, C1_PT, 1'b1);
      send(128'(0), aes_decrypt(128'(0), C1_KEY), 1'b0);
      wait_idle();

      // reset around round 5, then a clean block
      send(C1_CT, C1_PT, 1'b0);
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (key_addr == 4'd5) ok = 1;
      end
      if (!ok) chk("round5_timeout", 128'(0), 128'(1));
      @(posedge clk); #1 n_rst = 1'b1;
      @(posedge clk); #1 n_rst = 1'b0;
      send(C1_CT, C1_PT, 1'b0);
      wait_idle();

      // key_ready low at reset release holds off acceptance
      n_rst = 1'b1; key_ready = 1'b0; in_valid = 1'b1; in_data = C1_CT;
      @(posedge clk); #1 n_rst = 1'b0;
      repeat (5) @(posedge clk);
      #1 key_ready = 1'b1;
      send(C1_CT, C1_PT, 1'b0);
      wait_idle();

      // random keys and ciphertexts, random output stalls
      for (int t = 0; t < 8; t++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         ct  = {$urandom, $urandom, $urandom, $urandom};
         set_key(key);
         out_ready = 1'($urandom_range(0, 1));
         send(ct, aes_decrypt(ct, key), 1'b0);
         if (!out_ready) begin
            wait_ov();
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         wait_idle();
      end

      ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0) ok = 1;
      end
      if (!ok) chk("drain_timeout", 128'(exp_q.size()), 128'(0));
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
